// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl_if
// Brief    : Bundle of UART, register-file and ALU signals for uart_cmd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   rx_p_data;
    logic                    rx_d_vld;
    logic                    rx_err;
    logic                    tx_busy;
    logic [DATA_WIDTH-1:0]   tx_p_data;
    logic                    tx_d_vld;
    logic                    rf_wr_en;
    logic                    rf_rd_en;
    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic [DATA_WIDTH-1:0]   rf_wr_data;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic                    rf_rd_vld;
    logic                    alu_en;
    logic [FUN_WIDTH-1:0]    alu_fun;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    alu_vld;
    logic                    alu_clk_en;
    logic                    cmd_drop;

    // Controller side
    modport master (
        input  rx_p_data, rx_d_vld, rx_err, tx_busy,
        input  rf_rd_data, rf_rd_vld, alu_out, alu_vld,
        output tx_p_data, tx_d_vld, rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
        output alu_en, alu_fun, alu_clk_en, cmd_drop
    );

    // UART / register file / ALU side
    modport slave (
        output rx_p_data, rx_d_vld, rx_err, tx_busy,
        output rf_rd_data, rf_rd_vld, alu_out, alu_vld,
        input  tx_p_data, tx_d_vld, rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
        input  alu_en, alu_fun, alu_clk_en, cmd_drop
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Brief    : Parses UART command frames into register-file / ALU operations
//            and returns read data or ALU results as UART bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  wire logic       clk_i,
    input  wire logic       rst_n_i,
    uart_cmd_ctrl_if.master ctrl_bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_ADDR  = 4'd1;
    localparam logic [3:0] S_WR_DATA  = 4'd2;
    localparam logic [3:0] S_RD_ADDR  = 4'd3;
    localparam logic [3:0] S_RD_WAIT  = 4'd4;
    localparam logic [3:0] S_OP_A     = 4'd5;
    localparam logic [3:0] S_OP_B     = 4'd6;
    localparam logic [3:0] S_ALU_FUN  = 4'd7;
    localparam logic [3:0] S_ALU_WAIT = 4'd8;
    localparam logic [3:0] S_TX_LO    = 4'd9;
    localparam logic [3:0] S_TX_HI    = 4'd10;

    localparam logic [DATA_WIDTH-1:0] C_CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] C_CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] C_CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] C_CMD_ALU    = DATA_WIDTH'(8'hDD);

    logic [3:0]              state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   rf_addr_q,    rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic                    rf_wr_en_q,   rf_wr_en_d;
    logic                    rf_rd_en_q,   rf_rd_en_d;
    logic                    alu_en_q,     alu_en_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q,    alu_fun_d;
    logic [2*DATA_WIDTH-1:0] tx_buf_q,     tx_buf_d;
    logic                    tx_two_q,     tx_two_d;
    logic                    tx_vld_q,     tx_vld_d;
    logic [DATA_WIDTH-1:0]   tx_data_q,    tx_data_d;
    logic                    cmd_drop_q,   cmd_drop_d;

    logic w_rx_ok;
    logic w_rx_bad;
    logic w_in_payload;
    logic w_in_busy;

    assign w_rx_ok  = ctrl_bus.rx_d_vld & ~ctrl_bus.rx_err;
    assign w_rx_bad = ctrl_bus.rx_d_vld &  ctrl_bus.rx_err;

    assign w_in_payload = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                          (state_q == S_RD_ADDR) || (state_q == S_OP_A)    ||
                          (state_q == S_OP_B)    || (state_q == S_ALU_FUN);

    assign w_in_busy = (state_q == S_RD_WAIT) || (state_q == S_ALU_WAIT) ||
                       (state_q == S_TX_LO)   || (state_q == S_TX_HI);

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        tx_buf_d     = tx_buf_q;
        tx_two_d     = tx_two_q;
        tx_vld_d     = tx_vld_q;
        tx_data_d    = tx_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_drop_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_rx_bad) begin
                    cmd_drop_d = 1'b1;
                end else if (w_rx_ok) begin
                    case (ctrl_bus.rx_p_data)
                        C_CMD_WR:     state_d = S_WR_ADDR;
                        C_CMD_RD:     state_d = S_RD_ADDR;
                        C_CMD_ALU_OP: state_d = S_OP_A;
                        C_CMD_ALU:    state_d = S_ALU_FUN;
                        default:      cmd_drop_d = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (w_rx_ok) begin
                    rf_addr_d = ctrl_bus.rx_p_data[ADDR_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (w_rx_ok) begin
                    rf_wr_data_d = ctrl_bus.rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (w_rx_ok) begin
                    rf_addr_d  = ctrl_bus.rx_p_data[ADDR_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (ctrl_bus.rf_rd_vld) begin
                    tx_buf_d = {{DATA_WIDTH{1'b0}}, ctrl_bus.rf_rd_data};
                    tx_two_d = 1'b0;
                    state_d  = S_TX_LO;
                end
            end
            // Operands land in registers 0 and 1, where the ALU reads them
            S_OP_A: begin
                if (w_rx_ok) begin
                    rf_addr_d    = '0;
                    rf_wr_data_d = ctrl_bus.rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = S_OP_B;
                end
            end
            S_OP_B: begin
                if (w_rx_ok) begin
                    rf_addr_d    = ADDR_WIDTH'(1);
                    rf_wr_data_d = ctrl_bus.rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (w_rx_ok) begin
                    alu_fun_d = ctrl_bus.rx_p_data[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (ctrl_bus.alu_vld) begin
                    tx_buf_d = ctrl_bus.alu_out;
                    tx_two_d = 1'b1;
                    state_d  = S_TX_LO;
                end
            end
            S_TX_LO, S_TX_HI: begin
                // Request is held until busy is seen, then released; the
                // transmitter is never waited on beyond acceptance.
                if (tx_vld_q) begin
                    if (ctrl_bus.tx_busy) begin
                        tx_vld_d = 1'b0;
                        state_d  = ((state_q == S_TX_LO) && tx_two_q) ? S_TX_HI : S_IDLE;
                    end
                end else if (!ctrl_bus.tx_busy) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = (state_q == S_TX_LO) ? tx_buf_q[DATA_WIDTH-1:0]
                                                     : tx_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_in_payload && w_rx_bad) begin
            state_d    = S_IDLE;
            cmd_drop_d = 1'b1;
        end
        if (w_in_busy && ctrl_bus.rx_d_vld) begin
            cmd_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            tx_buf_q     <= '0;
            tx_two_q     <= 1'b0;
            tx_vld_q     <= 1'b0;
            tx_data_q    <= '0;
            cmd_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            tx_buf_q     <= tx_buf_d;
            tx_two_q     <= tx_two_d;
            tx_vld_q     <= tx_vld_d;
            tx_data_q    <= tx_data_d;
            cmd_drop_q   <= cmd_drop_d;
        end
    end

    assign ctrl_bus.tx_p_data  = tx_data_q;
    assign ctrl_bus.tx_d_vld   = tx_vld_q;
    assign ctrl_bus.rf_wr_en   = rf_wr_en_q;
    assign ctrl_bus.rf_rd_en   = rf_rd_en_q;
    assign ctrl_bus.rf_addr    = rf_addr_q;
    assign ctrl_bus.rf_wr_data = rf_wr_data_q;
    assign ctrl_bus.alu_en     = alu_en_q;
    assign ctrl_bus.alu_fun    = alu_fun_q;
    assign ctrl_bus.cmd_drop   = cmd_drop_q;
    assign ctrl_bus.alu_clk_en = (state_q == S_ALU_FUN) || (state_q == S_ALU_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Brief    : Random and directed command frames against a command-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

    uart_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .ctrl_bus (bus)
    );

    logic m_busy = 1'b0, hog_busy = 1'b0, tx_stall = 1'b0;
    logic env_rd_vld = 1'b0, spur_rd_vld = 1'b0, env_alu_vld = 1'b0, spur_alu_vld = 1'b0;
    assign bus.tx_busy   = m_busy | hog_busy;
    assign bus.rf_rd_vld = env_rd_vld | spur_rd_vld;
    assign bus.alu_vld   = env_alu_vld | spur_alu_vld;

    int n_chk = 0, n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f[1:0])
            2'd0:    alu_f = 16'(a) * 16'(b);
            2'd1:    alu_f = 16'(a) + 16'(b);
            2'd2:    alu_f = 16'(a) - 16'(b);
            default: alu_f = {a, b};
        endcase
    endfunction

    function automatic logic [31:0] outs();
        outs = {2'b0, bus.tx_p_data, bus.tx_d_vld, bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr,
                bus.rf_wr_data, bus.alu_en, bus.alu_fun, bus.alu_clk_en, bus.cmd_drop};
    endfunction

    // Environment register file contents (written by the DUT) and reference copy
    logic [7:0] env_mem [16];
    logic [7:0] ref_mem [16];

    int         obs_wr[$], obs_rd[$], obs_fun[$];
    logic [7:0] obs_tx[$];
    int         obs_drop = 0, proto_err = 0;
    int         exp_wr[$], exp_rd[$], exp_fun[$];
    logic [7:0] exp_tx[$];
    int         exp_drop = 0;

    logic [7:0] cb[$];
    int         err_pos;
    bit         extra;

    // Monitor: log strobes and check handshake rules
    initial begin
        logic pb, pv;
        logic [7:0] pd;
        pb = 1'b0; pv = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (bus.rf_wr_en) begin
                obs_wr.push_back(int'({bus.rf_addr, bus.rf_wr_data}));
                env_mem[bus.rf_addr] = bus.rf_wr_data;
            end
            if (bus.rf_rd_en) obs_rd.push_back(int'(bus.rf_addr));
            if (bus.alu_en)   obs_fun.push_back(int'(bus.alu_fun));
            if (bus.cmd_drop) obs_drop++;
            if (int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en) > 1) proto_err++;
            if (bus.alu_en && !bus.alu_clk_en) proto_err++;
            if (bus.alu_vld && !spur_alu_vld && !bus.alu_clk_en) proto_err++;
            if (bus.tx_d_vld && bus.alu_clk_en) proto_err++;
            if (bus.tx_d_vld && !pv && pb) proto_err++;
            if (bus.tx_d_vld && pv && pb) proto_err++;
            if (bus.tx_d_vld && pv && bus.tx_p_data !== pd) proto_err++;
            pb = bus.tx_busy; pv = bus.tx_d_vld; pd = bus.tx_p_data;
        end
    end

    // UART transmitter: accepts after a random delay, stays busy a while
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_d_vld && !hog_busy && !tx_stall) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(posedge clk); #1;
                if (bus.tx_d_vld) begin
                    m_busy = 1'b1;
                    obs_tx.push_back(bus.tx_p_data);
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1 m_busy = 1'b0;
                end
            end
        end
    end

    // Register file read port
    initial begin
        logic [3:0] a;
        bus.rf_rd_data = '0;
        forever begin
            @(negedge clk);
            if (bus.rf_rd_en) begin
                a = bus.rf_addr;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 bus.rf_rd_data = env_mem[a]; env_rd_vld = 1'b1;
                @(posedge clk);
                #1 env_rd_vld = 1'b0; bus.rf_rd_data = 8'($urandom);
            end
        end
    end

    // ALU: operates on registers 0 and 1
    initial begin
        logic [3:0] f;
        bus.alu_out = '0;
        forever begin
            @(negedge clk);
            if (bus.alu_en) begin
                f = bus.alu_fun;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 bus.alu_out = alu_f(env_mem[0], env_mem[1], f); env_alu_vld = 1'b1;
                @(posedge clk);
                #1 env_alu_vld = 1'b0; bus.alu_out = 16'($urandom);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            bus.rx_err = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.rx_err = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        bus.rx_p_data = b; bus.rx_err = e; bus.rx_d_vld = 1'b1;
        @(posedge clk); #1;
        bus.rx_d_vld = 1'b0; bus.rx_err = 1'b0; bus.rx_p_data = 8'($urandom);
    endtask

    task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        cb.delete();
        if (n > 0) cb.push_back(b0);
        if (n > 1) cb.push_back(b1);
        if (n > 2) cb.push_back(b2);
        if (n > 3) cb.push_back(b3);
    endtask

    // Expected effects of one frame, from the command table alone
    task automatic model_cmd();
        int n;
        logic [15:0] r;
        logic [7:0] b1;
        n = (err_pos >= 0) ? err_pos : cb.size();
        b1 = (cb.size() > 1) ? cb[1] : 8'h00;
        if (n >= 1) begin
            case (cb[0])
                8'hAA: if (n >= 3) begin
                    exp_wr.push_back(int'({b1[3:0], cb[2]}));
                    ref_mem[b1[3:0]] = cb[2];
                end
                8'hBB: if (n >= 2) begin
                    exp_rd.push_back(int'(b1[3:0]));
                    exp_tx.push_back(ref_mem[b1[3:0]]);
                end
                8'hCC: begin
                    if (n >= 2) begin exp_wr.push_back(int'({4'd0, cb[1]})); ref_mem[0] = cb[1]; end
                    if (n >= 3) begin exp_wr.push_back(int'({4'd1, cb[2]})); ref_mem[1] = cb[2]; end
                    if (n >= 4) begin
                        exp_fun.push_back(int'(cb[3] & 8'h0F));
                        r = alu_f(ref_mem[0], ref_mem[1], cb[3][3:0]);
                        exp_tx.push_back(r[7:0]);
                        exp_tx.push_back(r[15:8]);
                    end
                end
                8'hDD: if (n >= 2) begin
                    exp_fun.push_back(int'(b1[3:0]));
                    r = alu_f(ref_mem[0], ref_mem[1], b1[3:0]);
                    exp_tx.push_back(r[7:0]);
                    exp_tx.push_back(r[15:8]);
                end
                default: exp_drop++;
            endcase
        end
        if (err_pos >= 0) exp_drop++;
        if (extra) exp_drop++;
    endtask

    task automatic clear_all();
        obs_wr.delete(); obs_rd.delete(); obs_fun.delete(); obs_tx.delete();
        exp_wr.delete(); exp_rd.delete(); exp_fun.delete(); exp_tx.delete();
        obs_drop = 0; exp_drop = 0; proto_err = 0;
    endtask

    task automatic compare(input string nm);
        chk_eq({nm, ".wr_n"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk_eq({nm, ".wr"}, obs_wr[i], exp_wr[i]);
        chk_eq({nm, ".rd_n"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            chk_eq({nm, ".rd"}, obs_rd[i], exp_rd[i]);
        chk_eq({nm, ".fun_n"}, obs_fun.size(), exp_fun.size());
        for (int i = 0; i < exp_fun.size() && i < obs_fun.size(); i++)
            chk_eq({nm, ".fun"}, obs_fun[i], exp_fun[i]);
        chk_eq({nm, ".tx_n"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            chk_eq({nm, ".tx"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
        chk_eq({nm, ".drop"}, obs_drop, exp_drop);
        chk_eq({nm, ".proto"}, proto_err, 0);
        clear_all();
    endtask

    task automatic do_cmd(input string nm);
        int last;
        model_cmd();
        last = (err_pos >= 0) ? err_pos : cb.size() - 1;
        for (int i = 0; i <= last; i++) begin
            send(cb[i], 1'(i == err_pos));
            if (i < last) idle($urandom_range(0, 2));
        end
        if (extra) send(8'($urandom), 1'b0);
        for (int k = 0; k < 400 && obs_tx.size() < exp_tx.size(); k++) idle(1);
        idle(8);
        compare(nm);
    endtask

    task automatic build(input int k);
        logic [7:0] u;
        case (k)
            0: load(3, 8'hAA, 8'($urandom), 8'($urandom), 8'h00);
            1: load(2, 8'hBB, 8'($urandom), 8'h00, 8'h00);
            2: load(4, 8'hCC, 8'($urandom), 8'($urandom), 8'($urandom));
            3: load(2, 8'hDD, 8'($urandom), 8'h00, 8'h00);
            default: begin
                do u = 8'($urandom);
                while (u == 8'hAA || u == 8'hBB || u == 8'hCC || u == 8'hDD);
                load(1, u, 8'h00, 8'h00, 8'h00);
            end
        endcase
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        bus.rx_p_data = '0; bus.rx_d_vld = 1'b0; bus.rx_err = 1'b0;
        for (int i = 0; i < 16; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
        #2 rst_n = 1'b0;
        #2 chk_eq("reset.outs", outs(), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        chk_eq("reset.idle_outs", outs(), 32'h0);
        clear_all();

        err_pos = -1; extra = 0;
        load(3, 8'hAA, 8'h05, 8'h3C, 8'h00); do_cmd("dir_wr");
        load(2, 8'hBB, 8'h05, 8'h00, 8'h00); do_cmd("dir_rd");
        load(4, 8'hCC, 8'h12, 8'h34, 8'h01); do_cmd("dir_alu");
        load(3, 8'hAA, 8'h05, 8'h99, 8'h00); err_pos = 2; do_cmd("dir_rxerr");
        err_pos = -1;
        load(1, 8'h77, 8'h00, 8'h00, 8'h00); do_cmd("dir_unknown");
        load(2, 8'hDD, 8'h02, 8'h00, 8'h00); extra = 1; do_cmd("dir_busydrop");
        extra = 0;

        // Response valids outside their wait states must be ignored
        spur_rd_vld = 1'b1; spur_alu_vld = 1'b1;
        @(posedge clk); #1 spur_rd_vld = 1'b0; spur_alu_vld = 1'b0;
        idle(6);
        compare("dir_spurious");

        // Transmitter busy with other traffic when the response is ready
        hog_busy = 1'b1;
        fork
            begin repeat (20) @(posedge clk); #1 hog_busy = 1'b0; end
        join_none
        load(2, 8'hBB, 8'h00, 8'h00, 8'h00); do_cmd("dir_hog");

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 5);
            err_pos = -1; extra = 0;
            if (kind == 5) begin
                build($urandom_range(0, 3));
                err_pos = $urandom_range(0, cb.size() - 1);
            end else begin
                build(kind);
                if (kind >= 1 && kind <= 3 && $urandom_range(0, 2) == 0) extra = 1;
            end
            do_cmd("rand");
        end

        // Asynchronous reset while a transmit request is pending
        err_pos = -1; extra = 0;
        tx_stall = 1'b1;
        send(8'hBB, 1'b0);
        send(8'h03, 1'b0);
        for (int k = 0; k < 30 && !bus.tx_d_vld; k++) idle(1);
        chk_eq("rst_mid.vld_before", 32'(bus.tx_d_vld), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_eq("rst_mid.outs", outs(), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_stall = 1'b0;
        idle(2);
        clear_all();
        load(3, 8'hAA, 8'h0A, 8'h5A, 8'h00); do_cmd("rst_mid.after");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
